// File: rtl/pma_region_checker.sv
// PMA region checker: classifies physical addresses against CVA6 region rules and returns
// results through a 2-entry in-order FIFO. Optional fault counter: PMA_CHECKER_FAULT_CNT_EN.

package config_pkg;
  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                NrNonIdempotentRules;
    logic [NrMaxRules*64-1:0]   NonIdempotentAddrBase;
    logic [NrMaxRules*64-1:0]   NonIdempotentLength;
    int unsigned                NrExecuteRegionRules;
    logic [NrMaxRules*64-1:0]   ExecuteRegionAddrBase;
    logic [NrMaxRules*64-1:0]   ExecuteRegionLength;
    int unsigned                NrCachedRegionRules;
    logic [NrMaxRules*64-1:0]   CachedRegionAddrBase;
    logic [NrMaxRules*64-1:0]   CachedRegionLength;
    bit                         NonIdemPotenceEn;
  } cva6_cfg_t;
endpackage

package cva6_config_pkg;
  // Debug (0x0, 4 KiB), boot ROM (0x1_0000, 64 KiB), DRAM (0x8000_0000, 1 GiB); I/O below DRAM.
  localparam config_pkg::cva6_cfg_t cva6_cfg = '{
    NrNonIdempotentRules:  1,
    NonIdempotentAddrBase: {960'h0, 64'h0},
    NonIdempotentLength:   {960'h0, 64'h8000_0000},
    NrExecuteRegionRules:  3,
    ExecuteRegionAddrBase: {832'h0, 64'h8000_0000, 64'h1_0000, 64'h0},
    ExecuteRegionLength:   {832'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
    NrCachedRegionRules:   1,
    CachedRegionAddrBase:  {960'h0, 64'h8000_0000},
    CachedRegionLength:    {960'h0, 64'h4000_0000},
    NonIdemPotenceEn:      1'b1
  };
endpackage

module pma_region_checker #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic        req_fetch_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_addr_o,
  output logic        rsp_exec_o,
  output logic        rsp_cached_o,
  output logic        rsp_nonidem_o,
  output logic        rsp_fault_o,
  output logic [15:0] fault_cnt_o
);
  localparam int NrMax = int'(config_pkg::NrMaxRules);

  function automatic logic rule_match(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] len);
    logic [64:0] end_addr;
    end_addr = {1'b0, base} + {1'b0, len};
    return (len != 64'd0) && (addr >= base) && ({1'b0, addr} < end_addr);
  endfunction

  logic [63:0] addr_q [2];
  logic        fetch_q [2];
  logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        ready_q;
  logic        push, pop, rsp_valid;
  logic [63:0] head_addr;
  logic        head_fetch;

  assign rsp_valid   = (count_q != 2'd0);
  assign req_ready_o = ready_q;
  assign push        = req_valid_i & ready_q & ~flush_i;
  assign pop         = rsp_valid & rsp_ready_i;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // ready is registered so it carries no combinational path from rsp_ready_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= 64'd0;
        fetch_q[i] <= 1'b0;
      end
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ready_q  <= (count_d != 2'd2);
      if (push) begin
        addr_q[wr_ptr_q]  <= req_addr_i;
        fetch_q[wr_ptr_q] <= req_fetch_i;
      end
    end
  end

  assign head_addr  = addr_q[rd_ptr_q];
  assign head_fetch = fetch_q[rd_ptr_q];

  // Region lookup works on the stored head address, so outputs never see req_addr_i directly
  logic [NrMax-1:0] exec_hit, cached_hit, nonidem_hit;

  for (genvar gi = 0; gi < NrMax; gi++) begin : g_rule
    if (gi < int'(CVA6Cfg.NrExecuteRegionRules)) begin : g_exec
      assign exec_hit[gi] = rule_match(head_addr, CVA6Cfg.ExecuteRegionAddrBase[64*gi +: 64],
                                       CVA6Cfg.ExecuteRegionLength[64*gi +: 64]);
    end else begin : g_no_exec
      assign exec_hit[gi] = 1'b0;
    end
    if (gi < int'(CVA6Cfg.NrCachedRegionRules)) begin : g_cached
      assign cached_hit[gi] = rule_match(head_addr, CVA6Cfg.CachedRegionAddrBase[64*gi +: 64],
                                         CVA6Cfg.CachedRegionLength[64*gi +: 64]);
    end else begin : g_no_cached
      assign cached_hit[gi] = 1'b0;
    end
    if (gi < int'(CVA6Cfg.NrNonIdempotentRules)) begin : g_nonidem
      assign nonidem_hit[gi] = rule_match(head_addr, CVA6Cfg.NonIdempotentAddrBase[64*gi +: 64],
                                          CVA6Cfg.NonIdempotentLength[64*gi +: 64]);
    end else begin : g_no_nonidem
      assign nonidem_hit[gi] = 1'b0;
    end
  end

  assign rsp_valid_o   = rsp_valid;
  assign rsp_addr_o    = rsp_valid ? head_addr : 64'd0;
  assign rsp_exec_o    = rsp_valid & (|exec_hit);
  assign rsp_cached_o  = rsp_valid & (|cached_hit);
  assign rsp_nonidem_o = rsp_valid & (|nonidem_hit) & CVA6Cfg.NonIdemPotenceEn;
  assign rsp_fault_o   = rsp_valid & head_fetch & ~(|exec_hit);

`ifdef PMA_CHECKER_FAULT_CNT_EN
  logic [15:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (pop && rsp_fault_o && (fault_cnt_q != 16'hFFFF)) fault_cnt_d = fault_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fault_cnt_q <= 16'd0;
    else       fault_cnt_q <= fault_cnt_d;
  end

  assign fault_cnt_o = fault_cnt_q;
`else
  assign fault_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pma_region_checker.sv
// Self-checking bench for pma_region_checker: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pma_region_checker;
  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_fetch, rsp_ready;
  logic [63:0] req_addr;
  logic        req_ready, rsp_valid, rsp_exec, rsp_cached, rsp_nonidem, rsp_fault;
  logic [63:0] rsp_addr;
  logic [15:0] fault_cnt;

  always #5 clk = ~clk;

  pma_region_checker dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_fetch_i(req_fetch),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_addr_o(rsp_addr),
    .rsp_exec_o(rsp_exec), .rsp_cached_o(rsp_cached), .rsp_nonidem_o(rsp_nonidem),
    .rsp_fault_o(rsp_fault), .fault_cnt_o(fault_cnt)
  );

`ifdef PMA_CHECKER_FAULT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct { logic [63:0] addr; bit fetch; } item_t;
  typedef struct { logic [63:0] addr; bit fetch; bit exec, cached, nonidem, fault; } vec_t;

  item_t       mq[$];
  bit          ready_m;
  int unsigned fcnt_m;
  int          n_cmp = 0, n_err = 0;

  // Address map of the default configuration, written out as plain intervals
  function automatic bit hit(input logic [63:0] a, input logic [63:0] b, input logic [63:0] l);
    return (l != 64'd0) && ({1'b0, a} >= {1'b0, b}) && ({1'b0, a} < ({1'b0, b} + {1'b0, l}));
  endfunction
  function automatic bit ref_exec(input logic [63:0] a);
    return hit(a, 64'h0, 64'h1000) || hit(a, 64'h1_0000, 64'h1_0000) ||
           hit(a, 64'h8000_0000, 64'h4000_0000);
  endfunction
  function automatic bit ref_cached(input logic [63:0] a);
    return hit(a, 64'h8000_0000, 64'h4000_0000);
  endfunction
  function automatic bit ref_nonidem(input logic [63:0] a);
    return hit(a, 64'h0, 64'h8000_0000);
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk1("req_ready", req_ready, ready_m);
    chk1("rsp_valid", rsp_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk64("rsp_addr", rsp_addr, mq[0].addr);
      chk1("rsp_exec", rsp_exec, ref_exec(mq[0].addr));
      chk1("rsp_cached", rsp_cached, ref_cached(mq[0].addr));
      chk1("rsp_nonidem", rsp_nonidem, ref_nonidem(mq[0].addr));
      chk1("rsp_fault", rsp_fault, mq[0].fetch && !ref_exec(mq[0].addr));
    end else begin
      chk64("rsp_idle_data", rsp_addr | {60'd0, rsp_exec, rsp_cached, rsp_nonidem, rsp_fault},
            64'd0);
    end
    chk64("fault_cnt", 64'(fault_cnt), 64'(fcnt_m));
  endtask

  // One clock: predict handshakes from pre-edge state, advance model, then compare
  task automatic cycle();
    bit    acc, pp;
    item_t head;
    acc = req_valid && ready_m && !rst;
    pp  = (mq.size() > 0) && rsp_ready && !rst;
    if (pp) head = mq[0];
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      ready_m = 1'b0;
      fcnt_m  = 0;
    end else begin
      if (pp) begin
        $display("rsp addr=%h fetch=%0d exec=%0d fault=%0d", head.addr, head.fetch,
                 ref_exec(head.addr), head.fetch && !ref_exec(head.addr));
        if (CntEn && head.fetch && !ref_exec(head.addr) && fcnt_m < 32'hFFFF) fcnt_m++;
      end
      if (flush) mq.delete();
      else begin
        if (pp)  void'(mq.pop_front());
        if (acc) mq.push_back('{addr: req_addr, fetch: req_fetch});
      end
      ready_m = (mq.size() < 2);
    end
    check_all();
  endtask

  task automatic drive(input bit v, input logic [63:0] a, input bit f);
    req_valid = v;
    req_addr  = a;
    req_fetch = f;
  endtask

  vec_t vt[11];
  logic [63:0] pool[8];

  initial begin
    vt[0]  = '{64'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{64'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{64'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{64'h0FFF,      1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{64'h1000,      1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{64'hBFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{64'h1_0000,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{64'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{64'h1_FFFF,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{64'h2_0000,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pool = '{64'h8000_0000, 64'h4000_0000, 64'hC000_0000, 64'h0FFF,
             64'h1000, 64'hBFFF_FFFF, 64'h1_8000, 64'h0};

    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    mq.delete(); ready_m = 1'b0; fcnt_m = 0;
    #1;
    check_all();
    cycle();
    req_valid = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = 1'b0;
    cycle();
    chk1("ready_after_reset", req_ready, 1'b1);

    // Directed vector table, one request at a time with rsp_ready high
    rsp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vt[i].addr, vt[i].fetch);
      cycle();
      chk1("vec_valid", rsp_valid, 1'b1);
      chk64("vec_addr", rsp_addr, vt[i].addr);
      chk64("vec_flags", {60'd0, rsp_exec, rsp_cached, rsp_nonidem, rsp_fault},
            {60'd0, vt[i].exec, vt[i].cached, vt[i].nonidem, vt[i].fault});
      req_valid = 1'b0;
      cycle();
      if (i == 1) chk64("fault_cnt_unmapped", 64'(fault_cnt), CntEn ? 64'd1 : 64'd0);
    end

    // Backpressure: A, B accepted, C held until space frees up
    rsp_ready = 1'b0;
    drive(1'b1, 64'h8000_0100, 1'b0); cycle();
    drive(1'b1, 64'h8000_0200, 1'b1); cycle();
    chk1("bp_ready_low", req_ready, 1'b0);
    drive(1'b1, 64'h8000_0300, 1'b0); cycle();
    chk64("bp_stall_A", rsp_addr, 64'h8000_0100);
    cycle();
    chk64("bp_stall_A2", rsp_addr, 64'h8000_0100);
    rsp_ready = 1'b1;
    cycle();
    chk64("bp_out_B", rsp_addr, 64'h8000_0200);
    cycle();
    chk64("bp_out_C", rsp_addr, 64'h8000_0300);
    req_valid = 1'b0;
    cycle();
    chk1("bp_drained", rsp_valid, 1'b0);

    // Flush while full, with a simultaneous request that must vanish
    rsp_ready = 1'b0;
    drive(1'b1, 64'h0000_0010, 1'b1); cycle();
    drive(1'b1, 64'h0000_0020, 1'b1); cycle();
    flush = 1'b1;
    drive(1'b1, 64'hDEAD_0000, 1'b0);
    cycle();
    chk1("flush_valid", rsp_valid, 1'b0);
    chk1("flush_ready", req_ready, 1'b1);
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("flush_no_output", rsp_valid, 1'b0);
    end

    // Reset with two entries buffered
    rsp_ready = 1'b0;
    drive(1'b1, 64'h8000_1000, 1'b0); cycle();
    drive(1'b1, 64'h4000_1000, 1'b1); cycle();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    mq.delete(); ready_m = 1'b0; fcnt_m = 0;
    chk1("rst_mid_valid", rsp_valid, 1'b0);
    check_all();
    cycle();
    rst = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    chk1("rst_release_ready", req_ready, 1'b1);
    chk1("rst_no_stale", rsp_valid, 1'b0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      req_fetch = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) req_addr = {$urandom(), $urandom()};
      else req_addr = pool[$urandom_range(0, 7)] + 64'($urandom_range(0, 2)) - 64'd1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
